// File: rtl/alu181_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu181_pkg
//  Purpose  : Shared 74181 function-select encodings and sequencer state type
//  Revision : 1.0  initial release
// ============================================================================
package alu181_pkg;

    // 74181 S3..S0 encodings for common operations (active-high data)
    localparam logic [3:0] FN_INC = 4'b0000;  // M=0, cin_n=0 : A plus 1
    localparam logic [3:0] FN_SUB = 4'b0110;  // M=0, cin_n=0 : A minus B
    localparam logic [3:0] FN_ADD = 4'b1001;  // M=0          : A plus B
    localparam logic [3:0] FN_XOR = 4'b0110;  // M=1          : A xor B
    localparam logic [3:0] FN_AND = 4'b1011;  // M=1          : A and B
    localparam logic [3:0] FN_OR  = 4'b1110;  // M=1          : A or B

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu181_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu181_nibble_sequencer
//  Purpose  : Drives one external 74181 slice a nibble per cycle, LSB first,
//             chaining the carry through a register, and returns the wide
//             result with final carry and A=B flag.
//  Revision : 1.0  initial release
// ============================================================================
module alu181_nibble_sequencer
    import alu181_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic [3:0]             req_s,
    input  logic                   req_m,
    input  logic                   req_cin_n,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_f,
    output logic                   rsp_cout_n,
    output logic                   rsp_aeqb,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_ci_n,
    input  logic [3:0]             alu_f,
    input  logic                   alu_co,
    input  logic                   alu_aeqb
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_f;
    logic [3:0]         r_s;
    logic               r_m;
    logic               r_carry_n;
    logic               r_eq;

    logic               w_req_fire;
    logic               w_last;
    logic [W-1:0]       w_a_sh;
    logic [W-1:0]       w_b_sh;

    assign w_req_fire = req_valid && (r_state == IDLE);
    assign w_last     = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, one RUN cycle per nibble, hold DONE until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req_fire) w_next = RUN;
            RUN:     if (w_last)     w_next = DONE;
            DONE:    if (rsp_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, per-nibble result assembly and carry/equality chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_f       <= '0;
            r_s       <= '0;
            r_m       <= 1'b0;
            r_carry_n <= 1'b1;
            r_eq      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_a       <= req_a;
                        r_b       <= req_b;
                        r_s       <= req_s;
                        r_m       <= req_m;
                        r_carry_n <= req_cin_n;
                        r_idx     <= '0;
                        r_eq      <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_f[4*k +: 4] <= alu_f;
                        end
                    end
                    r_eq <= r_eq & alu_aeqb;
                    // Logic mode has no inter-nibble carry
                    if (!r_m) begin
                        r_carry_n <= ~alu_co;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_a_sh = r_a >> {r_idx, 2'b00};
    assign w_b_sh = r_b >> {r_idx, 2'b00};

    // Slice inputs come only from registers during RUN; parked at reset values otherwise
    always_comb begin
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        alu_s    = 4'h0;
        alu_m    = 1'b0;
        alu_ci_n = 1'b1;
        if (r_state == RUN) begin
            alu_a    = w_a_sh[3:0];
            alu_b    = w_b_sh[3:0];
            alu_s    = r_s;
            alu_m    = r_m;
            alu_ci_n = r_carry_n;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign rsp_f      = r_f;
    assign rsp_cout_n = (r_state == DONE) ? (r_m | r_carry_n) : 1'b1;
    assign rsp_aeqb   = (r_state == DONE) & r_eq;

endmodule
`default_nettype wire

// File: tb/tb_alu181_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu181_nibble_sequencer
//  Purpose  : Self-checking bench pairing the sequencer with a 74181 slice
//             model; wide results compared against a datasheet-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu181_nibble_sequencer;
    import alu181_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [3:0]     req_s;
    logic           req_m;
    logic           req_cin_n;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_f;
    logic           rsp_cout_n;
    logic           rsp_aeqb;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic [3:0]     alu_s;
    logic           alu_m;
    logic           alu_ci_n;
    logic [3:0]     alu_f;
    logic           alu_co;
    logic           alu_aeqb;

    alu181_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .req_m      (req_m),
        .req_cin_n  (req_cin_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_f      (rsp_f),
        .rsp_cout_n (rsp_cout_n),
        .rsp_aeqb   (rsp_aeqb),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_ci_n   (alu_ci_n),
        .alu_f      (alu_f),
        .alu_co     (alu_co),
        .alu_aeqb   (alu_aeqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181 slice: F = X plus Y plus carry (arith) or ~(X xor Y) (logic)
    logic [3:0] sl_x;
    logic [3:0] sl_y;
    logic [4:0] sl_sum;
    always_comb begin
        sl_x     = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        sl_y     = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sl_sum   = {1'b0, sl_x} + {1'b0, sl_y} + {4'b0000, ~alu_ci_n};
        alu_f    = alu_m ? ~(sl_x ^ sl_y) : sl_sum[3:0];
        alu_co   = sl_sum[4];
        alu_aeqb = &alu_f;
    end

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout_n;
        logic         aeqb;
    } res_t;

    // Whole-word datasheet function table
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] s, input logic m, input logic cin_n);
        res_t         r;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ones;
        logic [W:0]   sum;
        ones = '1;
        x    = '0;
        y    = '0;
        r.f      = '0;
        r.cout_n = 1'b1;
        if (m) begin
            case (s)
                4'h0: r.f = ~a;
                4'h1: r.f = ~(a | b);
                4'h2: r.f = ~a & b;
                4'h3: r.f = '0;
                4'h4: r.f = ~(a & b);
                4'h5: r.f = ~b;
                4'h6: r.f = a ^ b;
                4'h7: r.f = a & ~b;
                4'h8: r.f = ~a | b;
                4'h9: r.f = ~(a ^ b);
                4'hA: r.f = b;
                4'hB: r.f = a & b;
                4'hC: r.f = ones;
                4'hD: r.f = a | ~b;
                4'hE: r.f = a | b;
                default: r.f = a;
            endcase
        end else begin
            case (s)
                4'h0: begin x = a;          y = '0;       end
                4'h1: begin x = a | b;      y = '0;       end
                4'h2: begin x = a | ~b;     y = '0;       end
                4'h3: begin x = ones;       y = '0;       end
                4'h4: begin x = a;          y = a & ~b;   end
                4'h5: begin x = a | b;      y = a & ~b;   end
                4'h6: begin x = a;          y = ~b;       end
                4'h7: begin x = a & ~b;     y = ones;     end
                4'h8: begin x = a;          y = a & b;    end
                4'h9: begin x = a;          y = b;        end
                4'hA: begin x = a | ~b;     y = a & b;    end
                4'hB: begin x = a & b;      y = ones;     end
                4'hC: begin x = a;          y = a;        end
                4'hD: begin x = a | b;      y = a;        end
                4'hE: begin x = a | ~b;     y = a;        end
                default: begin x = a;       y = ones;     end
            endcase
            sum      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cin_n};
            r.f      = sum[W-1:0];
            r.cout_n = ~sum[W];
        end
        r.aeqb = (r.f == ones);
        return r;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait (bounded) for the response, hold rsp_ready low
    // for `hold` cycles, then consume it. lat = edges from presenting to rsp_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin_n, input int hold,
                          output res_t r, output int lat, output bit to);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_s     = s;
        req_m     = m;
        req_cin_n = cin_n;
        req_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        req_s     = 4'($urandom);
        req_m     = 1'($urandom);
        req_cin_n = 1'($urandom);
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        to = !rsp_valid;
        repeat (hold) @(negedge clk);
        r.f      = rsp_f;
        r.cout_n = rsp_cout_n;
        r.aeqb   = rsp_aeqb;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         cin_n;
        logic [W-1:0] f;
        logic         cout_n;
        logic         aeqb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        res_t r;
        res_t e;
        int   lat;
        bit   to;
        int   n;

        vecs[0] = '{"add",     16'h1234, 16'h0FCD, FN_ADD, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0};
        vecs[1] = '{"add_ovf", 16'hFFFF, 16'h0001, FN_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{"inc",     16'h00FF, 16'h0000, FN_INC, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0};
        vecs[3] = '{"cmp_eq",  16'hA5A5, 16'hA5A5, FN_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[4] = '{"cmp_ne",  16'hA5A5, 16'hA5A4, FN_SUB, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{"xor",     16'hF0F0, 16'hFF00, FN_XOR, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        req_m     = 1'b0;
        req_cin_n = 1'b1;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_rsp_f",      32'(rsp_f), 32'h0);
        chk("rst_rsp_cout_n", 32'(rsp_cout_n), 32'h1);
        chk("rst_rsp_aeqb",   32'(rsp_aeqb), 32'h0);
        chk("rst_rsp_valid",  32'(rsp_valid), 32'h0);
        chk("rst_req_ready",  32'(req_ready), 32'h1);
        chk("rst_alu_abs_m",  32'({alu_a, alu_b, alu_s, alu_m}), 32'h0);
        chk("rst_alu_ci_n",   32'(alu_ci_n), 32'h1);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin_n, 0, r, lat, to);
            chk({vecs[i].name, "_timeout"}, 32'(to), 32'h0);
            chk({vecs[i].name, "_f"},       32'(r.f), 32'(vecs[i].f));
            chk({vecs[i].name, "_cout_n"},  32'(r.cout_n), 32'(vecs[i].cout_n));
            chk({vecs[i].name, "_aeqb"},    32'(r.aeqb), 32'(vecs[i].aeqb));
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(N + 1));
            chk({vecs[i].name, "_idle"},    32'({req_ready, rsp_valid}), 32'b10);
        end

        // Backpressure: response held, new request ignored
        @(negedge clk);
        req_a = 16'h1234; req_b = 16'h0FCD; req_s = FN_ADD; req_m = 1'b0; req_cin_n = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_timeout", 32'(rsp_valid), 32'h1);
        req_a = 16'h1111; req_b = 16'h2222; req_s = FN_OR; req_m = 1'b1; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid",     32'(rsp_valid), 32'h1);
            chk("bp_f",         32'(rsp_f), 32'h2201);
            chk("bp_cout_aeqb", 32'({rsp_cout_n, rsp_aeqb}), 32'b10);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_release_state", 32'({req_ready, rsp_valid}), 32'b10);
        chk("bp_release_f",     32'(rsp_f), 32'h2201);

        // Reset mid-RUN after nibble 1 (carry pending into nibble 2)
        @(negedge clk);
        req_a = 16'hFFFF; req_b = 16'h0001; req_s = FN_ADD; req_m = 1'b0; req_cin_n = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_run_ci_before", 32'(alu_ci_n), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_ci_n",  32'(alu_ci_n), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'h0);
        run_op(16'h0001, 16'h0001, FN_ADD, 1'b0, 1'b1, 0, r, lat, to);
        chk("post_rst_timeout", 32'(to), 32'h0);
        chk("post_rst_f",       32'(r.f), 32'h0002);
        chk("post_rst_cout_n",  32'(r.cout_n), 32'h1);

        // Randomized operations against the whole-word model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [3:0]   s;
            logic         m;
            logic         ci;
            a  = W'($urandom);
            b  = (i % 5 == 0) ? a : W'($urandom);
            s  = 4'($urandom);
            m  = 1'($urandom);
            ci = 1'($urandom);
            e  = ref_op(a, b, s, m, ci);
            run_op(a, b, s, m, ci, int'($urandom_range(0, 3)), r, lat, to);
            chk("rnd_timeout", 32'(to), 32'h0);
            chk("rnd_f",       32'(r.f), 32'(e.f));
            chk("rnd_cout_n",  32'(r.cout_n), 32'(e.cout_n));
            chk("rnd_aeqb",    32'(r.aeqb), 32'(e.aeqb));
            chk("rnd_latency", 32'(lat), 32'(N + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
